// File: rtl/huff_sort_pkg.sv
// Shared definitions for the Huffman frequency-sort stage: FSM state codes,
// the pad entry and key/symbol field-extract helpers.
package huff_sort_pkg;

   localparam int HS_DSIZE  = 18;
   localparam int HS_OFFSET = 8;
   localparam int HS_MAXW   = 32;

   // State enumeration kept as plain constants so older tools can consume it
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SORT  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [HS_DSIZE-1:0] HS_PAD = {HS_DSIZE{1'b1}};

   function automatic logic [HS_MAXW-1:0] key_of(input logic [HS_MAXW-1:0] entry,
                                                  input int offset);
      return entry >> offset;
   endfunction

   function automatic logic [HS_MAXW-1:0] sym_of(input logic [HS_MAXW-1:0] entry,
                                                  input int offset);
      return entry & ((HS_MAXW'(1) << offset) - HS_MAXW'(1));
   endfunction

endpackage

// File: rtl/sort_x8_batch_ctrl_sortx8.sv
// SortX8: purely combinational 8-entry ascending sort on the key field.
// Odd-even transposition network; the symbol field rides along untouched.
module SortX8
   import huff_sort_pkg::*;
#(
   parameter int DSIZE  = 18,
   parameter int OFFSET = 8
) (
   input  logic [DSIZE-1:0] i_data [8],
   output logic [DSIZE-1:0] o_data [8]
);

   logic [DSIZE-1:0] w_net [8];
   logic [DSIZE-1:0] w_tmp;

   // Eight alternating stages of neighbour compare-exchange fully sort 8 items
   always_comb begin
      w_net = i_data;
      w_tmp = '0;
      for (int s = 0; s < 8; s++) begin
         for (int p = s % 2; p < 7; p += 2) begin
            if (key_of(HS_MAXW'(w_net[p]), OFFSET) > key_of(HS_MAXW'(w_net[p+1]), OFFSET)) begin
               w_tmp      = w_net[p];
               w_net[p]   = w_net[p+1];
               w_net[p+1] = w_tmp;
            end
         end
      end
      o_data = w_net;
   end

endmodule

// File: rtl/sort_x8_batch_ctrl.sv
// Batch sequencer around SortX8: gathers up to 8 entries, pads, sorts, drains.
// Define SORT_X8_SKIP_PAD_EN to drain only the real entries instead of all 8.
module sort_x8_batch_ctrl
   import huff_sort_pkg::*;
#(
   parameter int DSIZE  = 18,
   parameter int OFFSET = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DSIZE-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DSIZE-1:0] out_data,
   output logic             out_last,
   output logic             out_frame_last,
   output logic             busy
);

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;
   logic             r_inReady;
   logic [3:0]       r_cnt;
   logic [2:0]       r_idx;
   logic             r_frameFlag;
   logic [DSIZE-1:0] r_slot [8];
   logic [DSIZE-1:0] r_res  [8];
   logic [DSIZE-1:0] w_sortIn  [8];
   logic [DSIZE-1:0] w_sortOut [8];
   logic             w_accept;
   logic             w_drainHs;
   logic [2:0]       w_lastIdx;

   assign w_accept  = in_valid & r_inReady;
   assign w_drainHs = (r_state == ST_DRAIN) & out_ready;

`ifdef SORT_X8_SKIP_PAD_EN
   assign w_lastIdx = 3'(r_cnt - 4'd1);
`else
   assign w_lastIdx = 3'd7;
`endif

   // Unfilled slots are forced to the all-ones pad so they sort to the top
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_sortIn[i] = (4'(i) < r_cnt) ? r_slot[i] : {DSIZE{1'b1}};
      end
   end

   SortX8 #(.DSIZE(DSIZE), .OFFSET(OFFSET)) uSort (
      .i_data (w_sortIn),
      .o_data (w_sortOut)
   );

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_nextState = in_last ? ST_SORT : ST_LOAD;
         ST_LOAD:  if (w_accept && (in_last || r_cnt == 4'd7)) w_nextState = ST_SORT;
         ST_SORT:  w_nextState = ST_DRAIN;
         ST_DRAIN: if (w_drainHs && r_idx == w_lastIdx) w_nextState = ST_IDLE;
         default:  w_nextState = ST_IDLE;
      endcase
   end

   // in_ready is registered from the next state so it never follows in_valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_inReady   <= 1'b0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_frameFlag <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_slot[i] <= '0;
            r_res[i]  <= '0;
         end
      end else begin
         r_state   <= w_nextState;
         r_inReady <= (w_nextState == ST_IDLE) || (w_nextState == ST_LOAD);
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_slot[0]   <= in_data;
                  r_cnt       <= 4'd1;
                  r_frameFlag <= in_last;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  r_slot[r_cnt[2:0]] <= in_data;
                  r_cnt              <= r_cnt + 4'd1;
                  r_frameFlag        <= in_last;
               end
            end
            ST_SORT: begin
               r_res <= w_sortOut;
            end
            ST_DRAIN: begin
               if (w_drainHs) begin
                  if (r_idx == w_lastIdx) begin
                     r_idx <= '0;
                     r_cnt <= '0;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready       = r_inReady;
   assign out_valid      = (r_state == ST_DRAIN);
   assign out_data       = out_valid ? r_res[r_idx] : '0;
   assign out_last       = out_valid && (r_idx == w_lastIdx);
   assign out_frame_last = out_last & r_frameFlag;
   assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sort_x8_batch_ctrl.sv
// Directed self-checking bench for sort_x8_batch_ctrl (either SORT_X8_SKIP_PAD_EN build).
module tb_sort_x8_batch_ctrl;
   import huff_sort_pkg::*;

   localparam int DW = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_frame_last;
   logic          busy;

   int nChecks = 0;
   int nFails  = 0;

   logic [DW-1:0] capData  [16];
   logic          capLast  [16];
   logic          capFlast [16];
   int            capN;

   localparam int K8[8]  = '{7, 3, 9, 1, 8, 2, 6, 4};
   localparam int EK8[8] = '{1, 2, 3, 4, 6, 7, 8, 9};
   localparam int ES8[8] = '{3, 5, 1, 7, 6, 0, 4, 2};

   sort_x8_batch_ctrl #(.DSIZE(DW), .OFFSET(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .out_frame_last (out_frame_last),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk(input int key, input int sym);
      return DW'((key << 8) | sym);
   endfunction

   // Present one entry and hold it until the block accepts it
   task automatic send(input logic [DW-1:0] d, input logic last);
      int cyc = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      nChecks++;
      if (!in_ready) begin
         $display("[TB] FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, cyc);
         nFails++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Record n outputs with out_ready held high
   task automatic collect(input int n);
      int cyc = 0;
      capN = 0;
      out_ready = 1'b1;
      while (capN < n && cyc < 300) begin
         if (out_valid) begin
            capData[capN]  = out_data;
            capLast[capN]  = out_last;
            capFlast[capN] = out_frame_last;
            capN++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      nChecks++;
      if (capN != n) begin
         $display("[TB] FAIL collect_timeout: got %0d outputs, required %0d", capN, n);
         nFails++;
      end
   endtask

   task automatic load_k8(input logic lastOn8th);
      for (int i = 0; i < 8; i++) send(mk(K8[i], i), (i == 7) ? lastOn8th : 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nChecks += 6;
      if (in_ready !== 1'b0) begin $display("[TB] FAIL reset_in_ready: got %0b, required 0", in_ready); nFails++; end
      if (out_valid !== 1'b0) begin $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); nFails++; end
      if (out_data !== '0) begin $display("[TB] FAIL reset_out_data: got %h, required 0", out_data); nFails++; end
      if (out_last !== 1'b0) begin $display("[TB] FAIL reset_out_last: got %0b, required 0", out_last); nFails++; end
      if (out_frame_last !== 1'b0) begin $display("[TB] FAIL reset_frame_last: got %0b, required 0", out_frame_last); nFails++; end
      if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy: got %0b, required 0", busy); nFails++; end
      rst = 1'b0;
      @(posedge clk); #1;
      nChecks++;
      if (in_ready !== 1'b1) begin $display("[TB] FAIL post_reset_in_ready: got %0b, required 1", in_ready); nFails++; end
   endtask

   task automatic test_full_batch();
      load_k8(1'b0);
      nChecks += 3;
      if (out_valid !== 1'b0) begin $display("[TB] FAIL full_sort_valid: got %0b, required 0", out_valid); nFails++; end
      if (in_ready !== 1'b0) begin $display("[TB] FAIL full_sort_in_ready: got %0b, required 0", in_ready); nFails++; end
      if (busy !== 1'b1) begin $display("[TB] FAIL full_sort_busy: got %0b, required 1", busy); nFails++; end
      @(posedge clk); #1;
      nChecks++;
      if (out_valid !== 1'b1) begin $display("[TB] FAIL full_latency: out_valid=%0b at t+2, required 1", out_valid); nFails++; end
      collect(8);
      for (int i = 0; i < capN; i++) begin
         nChecks += 3;
         if (capData[i] !== mk(EK8[i], ES8[i])) begin
            $display("[TB] FAIL full_data[%0d]: got %h, required %h", i, capData[i], mk(EK8[i], ES8[i])); nFails++;
         end
         if (capLast[i] !== (i == 7)) begin
            $display("[TB] FAIL full_last[%0d]: got %0b, required %0b", i, capLast[i], (i == 7)); nFails++;
         end
         if (capFlast[i] !== 1'b0) begin
            $display("[TB] FAIL full_frame_last[%0d]: got %0b, required 0", i, capFlast[i]); nFails++;
         end
      end
      nChecks += 2;
      if (busy !== 1'b0) begin $display("[TB] FAIL full_idle_busy: got %0b, required 0", busy); nFails++; end
      if (in_ready !== 1'b1) begin $display("[TB] FAIL full_idle_in_ready: got %0b, required 1", in_ready); nFails++; end
   endtask

   task automatic test_partial();
      int n;
      send(mk(5, 8'h0A), 1'b0);
      send(mk(0, 8'h0B), 1'b0);
      send(mk(5, 8'h0C), 1'b1);
`ifdef SORT_X8_SKIP_PAD_EN
      n = 3;
`else
      n = 8;
`endif
      collect(n);
      nChecks += 3;
      if (capData[0] !== mk(0, 8'h0B)) begin $display("[TB] FAIL part_data0: got %h, required %h", capData[0], mk(0, 8'h0B)); nFails++; end
      if (key_of(32'(capData[1]), 8) !== 32'd5) begin $display("[TB] FAIL part_key1: got %h, required 5", capData[1]); nFails++; end
      if (key_of(32'(capData[2]), 8) !== 32'd5) begin $display("[TB] FAIL part_key2: got %h, required 5", capData[2]); nFails++; end
      for (int i = 3; i < capN; i++) begin
         nChecks++;
         if (capData[i] !== HS_PAD) begin $display("[TB] FAIL part_pad[%0d]: got %h, required %h", i, capData[i], HS_PAD); nFails++; end
      end
      for (int i = 0; i < capN; i++) begin
         nChecks += 2;
         if (capLast[i] !== (i == n - 1)) begin
            $display("[TB] FAIL part_last[%0d]: got %0b, required %0b", i, capLast[i], (i == n - 1)); nFails++;
         end
         if (capFlast[i] !== (i == n - 1)) begin
            $display("[TB] FAIL part_frame_last[%0d]: got %0b, required %0b", i, capFlast[i], (i == n - 1)); nFails++;
         end
      end
      nChecks++;
      if (busy !== 1'b0) begin $display("[TB] FAIL part_idle_busy: got %0b, required 0", busy); nFails++; end
   endtask

   task automatic test_backpressure();
      logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic          prevValid = 1'b0;
      logic          prevReady = 1'b1;
      logic [DW-1:0] prevData = '0;
      int            cyc = 0;
      int            k = 0;
      out_ready = 1'b0;
      load_k8(1'b0);
      capN = 0;
      while (capN < 8 && cyc < 60) begin
         if (out_valid) begin
            out_ready = (k < 4) ? pat[k] : 1'b1;
            k++;
         end else begin
            out_ready = 1'b0;
         end
         if (prevValid && !prevReady) begin
            nChecks += 2;
            if (out_valid !== 1'b1) begin $display("[TB] FAIL bp_hold_valid: got %0b, required 1", out_valid); nFails++; end
            if (out_data !== prevData) begin $display("[TB] FAIL bp_hold_data: got %h, required %h", out_data, prevData); nFails++; end
         end
         if (out_valid) begin
            nChecks++;
            if (in_ready !== 1'b0) begin $display("[TB] FAIL bp_in_ready: got %0b, required 0", in_ready); nFails++; end
            if (out_ready) begin
               capData[capN] = out_data;
               capN++;
            end
         end
         prevValid = out_valid;
         prevReady = out_ready;
         prevData  = out_data;
         @(posedge clk); #1;
         cyc++;
      end
      nChecks++;
      if (capN != 8) begin $display("[TB] FAIL bp_count: got %0d outputs, required 8", capN); nFails++; end
      for (int i = 0; i < capN; i++) begin
         nChecks++;
         if (capData[i] !== mk(EK8[i], ES8[i])) begin
            $display("[TB] FAIL bp_data[%0d]: got %h, required %h", i, capData[i], mk(EK8[i], ES8[i])); nFails++;
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_mid_drain_reset();
      logic [7:0] seen = '0;
      load_k8(1'b0);
      collect(3);
      for (int i = 0; i < capN; i++) begin
         nChecks++;
         if (capData[i] !== mk(EK8[i], ES8[i])) begin
            $display("[TB] FAIL mdr_pre_data[%0d]: got %h, required %h", i, capData[i], mk(EK8[i], ES8[i])); nFails++;
         end
      end
      rst = 1'b1;
      #1;
      nChecks += 6;
      if (out_valid !== 1'b0) begin $display("[TB] FAIL mdr_out_valid: got %0b, required 0", out_valid); nFails++; end
      if (out_data !== '0) begin $display("[TB] FAIL mdr_out_data: got %h, required 0", out_data); nFails++; end
      if (out_last !== 1'b0) begin $display("[TB] FAIL mdr_out_last: got %0b, required 0", out_last); nFails++; end
      if (out_frame_last !== 1'b0) begin $display("[TB] FAIL mdr_frame_last: got %0b, required 0", out_frame_last); nFails++; end
      if (busy !== 1'b0) begin $display("[TB] FAIL mdr_busy: got %0b, required 0", busy); nFails++; end
      if (in_ready !== 1'b0) begin $display("[TB] FAIL mdr_in_ready: got %0b, required 0", in_ready); nFails++; end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send(mk(10, i), (i == 7));
      collect(8);
      for (int i = 0; i < capN; i++) begin
         nChecks += 3;
         if (key_of(32'(capData[i]), 8) !== 32'd10) begin
            $display("[TB] FAIL mdr_key[%0d]: got %h, required key 10", i, capData[i]); nFails++;
         end
         if (capLast[i] !== (i == 7)) begin
            $display("[TB] FAIL mdr_last[%0d]: got %0b, required %0b", i, capLast[i], (i == 7)); nFails++;
         end
         if (capFlast[i] !== (i == 7)) begin
            $display("[TB] FAIL mdr_frame_last[%0d]: got %0b, required %0b", i, capFlast[i], (i == 7)); nFails++;
         end
         if (sym_of(32'(capData[i]), 8) < 32'd8) seen[sym_of(32'(capData[i]), 8)] = 1'b1;
      end
      nChecks++;
      if (seen !== 8'hFF) begin $display("[TB] FAIL mdr_symbols: seen mask %h, required ff", seen); nFails++; end
   endtask

   task automatic test_back_to_back();
      int n;
`ifdef SORT_X8_SKIP_PAD_EN
      n = 11;
`else
      n = 16;
`endif
      fork
         for (int i = 0; i < 11; i++) send(mk(30 - i, i), (i == 10));
         collect(n);
      join
      for (int i = 0; i < 8 && i < capN; i++) begin
         nChecks += 3;
         if (capData[i] !== mk(23 + i, 7 - i)) begin
            $display("[TB] FAIL b2b_data1[%0d]: got %h, required %h", i, capData[i], mk(23 + i, 7 - i)); nFails++;
         end
         if (capLast[i] !== (i == 7)) begin
            $display("[TB] FAIL b2b_last1[%0d]: got %0b, required %0b", i, capLast[i], (i == 7)); nFails++;
         end
         if (capFlast[i] !== 1'b0) begin
            $display("[TB] FAIL b2b_frame_last1[%0d]: got %0b, required 0", i, capFlast[i]); nFails++;
         end
      end
      for (int i = 8; i < capN; i++) begin
         nChecks += 3;
         if (i < 11 && capData[i] !== mk(12 + i, 18 - i)) begin
            $display("[TB] FAIL b2b_data2[%0d]: got %h, required %h", i, capData[i], mk(12 + i, 18 - i)); nFails++;
         end
         if (i >= 11 && capData[i] !== HS_PAD) begin
            $display("[TB] FAIL b2b_pad2[%0d]: got %h, required %h", i, capData[i], HS_PAD); nFails++;
         end
         if (capLast[i] !== (i == n - 1)) begin
            $display("[TB] FAIL b2b_last2[%0d]: got %0b, required %0b", i, capLast[i], (i == n - 1)); nFails++;
         end
         if (capFlast[i] !== (i == n - 1)) begin
            $display("[TB] FAIL b2b_frame_last2[%0d]: got %0b, required %0b", i, capFlast[i], (i == n - 1)); nFails++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_partial();
      test_backpressure();
      test_mid_drain_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/sort_x8_batch_ctrl.md
# sort_x8_batch_ctrl

Sequencer that feeds the 8-input combinational sort network (`SortX8`) in the canonical Huffman frequency-sort stage. It gathers up to 8 `{key, symbol}` entries from a valid/ready stream and pads short batches. It registers the sorted result and drains it serially, smallest key first, to the code-length builder downstream.

## Interface
- `DSIZE`, 18: entry width; `entry[DSIZE-1:OFFSET]` = key (frequency), `entry[OFFSET-1:0]` = symbol
- `OFFSET`, 8: key/symbol split point; passed unchanged to the sort network
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: input entry valid
- `in_ready` out 1: block accepts an entry this cycle
- `in_data` in DSIZE: input entry
- `in_last` in 1: final entry of the frame; closes the current batch
- `out_valid` out 1: sorted entry valid
- `out_ready` in 1: downstream accepts entry
- `out_data` out DSIZE: sorted entry, ascending key
- `out_last` out 1: final emitted entry of the batch
- `out_frame_last` out 1: `out_last` of a batch closed by `in_last`
- `busy` out 1: state ≠ IDLE

## Operation
- States:
  - IDLE: `in_ready`=1. First accepted entry is written to slot 0, `cnt`=1, and the FSM goes to LOAD. If that entry has `in_last` or `cnt` reaches 8, it goes to SORT instead.
  - LOAD: `in_ready`=1. Each accepted entry is written to slot `cnt` and `cnt` increments. Goes to SORT when the 8th entry is accepted or `in_last` is accepted.
  - SORT: `in_ready`=0 for exactly one cycle. Slots `cnt`..7 hold the pad value; the sort network sorts all 8 slots. The 8 sorted outputs are captured into `res[0..7]`. `frame_flag` takes the accepted `in_last`. Goes to DRAIN.
  - DRAIN: `out_valid`=1 and `out_data`=`res[idx]`. Each `out_valid & out_ready` increments `idx`. The handshake at the last emitted index returns the FSM to IDLE and clears `idx` and `cnt`.
- Pad value is all ones. Pads sort to the top, so the smallest `cnt` results are exactly the real entries. A real all-ones entry is indistinguishable from a pad and emits correctly.
- `cnt` is 4 bits, range 1..8; `idx` is 3 bits.
- Order among equal keys is whatever the network produces. No stability guarantee.
- `in_ready` is a registered function of state only. It never depends on `in_valid`.
- `out_data` and `out_valid` must stay stable while `out_valid & !out_ready`.
- `in_last` with `in_valid=0` is ignored.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, then 1 (IDLE). `out_valid`=0, `out_data`=0, `out_last`=0, `out_frame_last`=0, `busy`=0. `cnt`, `idx`, slots and `res` are cleared.
- Latency: last entry accepted in cycle t → SORT in t+1 → first `out_valid` in t+2.
- Full batch with no backpressure: 8 load + 1 sort + 8 drain = 17 cycles. No overlap of load and drain.
- `rst` asserted mid-LOAD or mid-DRAIN: immediate return to IDLE and the partial batch is discarded. After release, the first accepted entry starts a new batch.
- `in_last` on the 8th entry: normal full batch with `frame_flag`=1.

## Configuration
- `SORT_X8_SKIP_PAD_EN` defined:
  - DRAIN emits only `cnt` entries.
  - `out_last` is asserted at `idx`=`cnt`-1.
- `SORT_X8_SKIP_PAD_EN` not defined:
  - DRAIN always emits 8 entries, including pads.
  - `out_last` is asserted at `idx`=7.
- In both builds, `out_frame_last` = `out_last & frame_flag`.

## Structure
- Shared package `huff_sort_pkg` holds:
  - the state enum (IDLE/LOAD/SORT/DRAIN)
  - the pad constant `{DSIZE{1'b1}}`
  - the `key_of`/`sym_of` field-extract helpers
- One sub-module: `SortX8`, instantiated once on the slot registers with `DSIZE` and `OFFSET` passed through. The controller adds no comparators of its own.

## Test plan
- Full batch: keys 7,3,9,1,8,2,6,4 with symbols 0..7 and `out_ready`=1 → outputs keys 1,2,3,4,6,7,8,9 with symbols 3,5,1,7,6,0,4,2. `out_last` on the 8th output; first output at t+2.
- Partial batch (SKIP_PAD on): 3 entries with keys 5,0,5 and `in_last` on the third → 3 outputs with keys 0,5,5. `out_last` and `out_frame_last` on the third output.
- Partial batch (SKIP_PAD off): same stimulus → 8 outputs; outputs 3..7 = 0x3FFFF. `out_frame_last` on the 8th output.
- Backpressure: toggle `out_ready` 1,0,0,1 during DRAIN → `out_data` is held over stalled cycles, no entry is lost or duplicated, and `in_ready` stays 0.
- Mid-drain reset: assert `rst` after 3 of 8 outputs → all outputs return to their reset values. The next batch of key 10 ×8 emits 8 entries with key 10, with no stale data.
- Back-to-back frames: 11 entries with `in_last` on the 11th → batch of 8 with `out_frame_last`=0, then batch of 3 with `out_frame_last`=1.
